// File: rtl/mic1_microsequencer.sv
// MIC-1 microsequencer: owns MPC, fetches microinstructions, computes the
// next address from NEXT_ADDRESS/JAM bits, and arbitrates the store write port.
module mic1_microsequencer #(
    parameter int                ADDR_W    = 9,
    parameter int                WORD_W    = 36,
    parameter logic [ADDR_W-1:0] RESET_MPC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_en,
    output logic              cs_ren,
    output logic [ADDR_W-1:0] cs_raddr,
    input  logic [WORD_W-1:0] cs_rdata,
    output logic              cs_wen,
    output logic [ADDR_W-1:0] cs_waddr,
    output logic [WORD_W-1:0] cs_wdata,
    output logic              mir_valid,
    input  logic              exec_done,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic [7:0]        mbr,
    input  logic              load_req,
    output logic              load_ack,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic [ADDR_W-1:0] mpc,
    output logic              busy
);

    if (ADDR_W != 9) begin : g_bad_addr_w
        $error("mic1_microsequencer: ADDR_W must be 9");
    end
    if (WORD_W != 36) begin : g_bad_word_w
        $error("mic1_microsequencer: WORD_W must be 36");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LOAD
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_mpc;
    logic                r_cs_ren;
    logic                r_cs_wen;
    logic [ADDR_W-1:0]   r_cs_waddr;
    logic [WORD_W-1:0]   r_cs_wdata;
    logic                r_mir_valid;
    logic                r_load_ack;
    logic                r_busy;

    logic [ADDR_W-1:0]   w_na;
    logic                w_jmpc;
    logic                w_jamn;
    logic                w_jamz;
    logic [ADDR_W-1:0]   w_next;
    logic                w_unused;

    // Microinstruction layout: NA[35:27] JMPC[26] JAMN[25] JAMZ[24]
    assign w_na     = cs_rdata[WORD_W-1 -: ADDR_W];
    assign w_jmpc   = cs_rdata[WORD_W-ADDR_W-1];
    assign w_jamn   = cs_rdata[WORD_W-ADDR_W-2];
    assign w_jamz   = cs_rdata[WORD_W-ADDR_W-3];
    assign w_unused = ^cs_rdata[WORD_W-ADDR_W-4:0];

    assign w_next = {
        w_na[8] | (w_jamz & alu_z) | (w_jamn & alu_n),
        w_jmpc ? (w_na[7:0] | mbr) : w_na[7:0]
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mpc       <= RESET_MPC;
            r_cs_ren    <= 1'b0;
            r_cs_wen    <= 1'b0;
            r_cs_waddr  <= '0;
            r_cs_wdata  <= '0;
            r_mir_valid <= 1'b0;
            r_load_ack  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_state    <= S_LOAD;
                        r_load_ack <= 1'b1;
                    end else if (run_en) begin
                        r_state  <= S_FETCH;
                        r_cs_ren <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_state     <= S_EXEC;
                    r_cs_ren    <= 1'b0;
                    r_mir_valid <= 1'b1;
                end
                S_EXEC: begin
                    // The MIR is never aborted; mode changes wait for exec_done
                    if (exec_done) begin
                        r_mpc       <= w_next;
                        r_mir_valid <= 1'b0;
                        if (load_req) begin
                            r_state    <= S_LOAD;
                            r_load_ack <= 1'b1;
                            r_busy     <= 1'b0;
                        end else if (run_en) begin
                            r_state  <= S_FETCH;
                            r_cs_ren <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_req) begin
                        r_cs_wen   <= load_we;
                        r_cs_waddr <= load_addr;
                        r_cs_wdata <= load_data;
                    end else begin
                        r_state    <= S_IDLE;
                        r_mpc      <= RESET_MPC;
                        r_load_ack <= 1'b0;
                        r_cs_wen   <= 1'b0;
                        r_cs_waddr <= '0;
                        r_cs_wdata <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cs_ren    = r_cs_ren;
    assign cs_raddr  = r_mpc;
    assign cs_wen    = r_cs_wen;
    assign cs_waddr  = r_cs_waddr;
    assign cs_wdata  = r_cs_wdata;
    assign mir_valid = r_mir_valid;
    assign load_ack  = r_load_ack;
    assign mpc       = r_mpc;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Bench for mic1_microsequencer: directed scenarios plus a random
// microprogram walk checked against a next-address reference model.
module tb_mic1_microsequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic        cs_ren;
    logic [8:0]  cs_raddr;
    logic [35:0] cs_rdata;
    logic        cs_wen;
    logic [8:0]  cs_waddr;
    logic [35:0] cs_wdata;
    logic        mir_valid;
    logic        exec_done;
    logic        alu_n;
    logic        alu_z;
    logic [7:0]  mbr;
    logic        load_req;
    logic        load_ack;
    logic        load_we;
    logic [8:0]  load_addr;
    logic [35:0] load_data;
    logic [8:0]  mpc;
    logic        busy;

    logic [35:0] mem  [0:511];
    logic [35:0] prog [0:511];
    logic        tb_we;
    logic [8:0]  tb_wa;
    logic [35:0] tb_wd;

    int n_pass  = 0;
    int n_total = 0;
    int n_coll  = 0;

    always #5 clk = ~clk;

    mic1_microsequencer #(
        .ADDR_W   (9),
        .WORD_W   (36),
        .RESET_MPC(9'h000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_en   (run_en),
        .cs_ren   (cs_ren),
        .cs_raddr (cs_raddr),
        .cs_rdata (cs_rdata),
        .cs_wen   (cs_wen),
        .cs_waddr (cs_waddr),
        .cs_wdata (cs_wdata),
        .mir_valid(mir_valid),
        .exec_done(exec_done),
        .alu_n    (alu_n),
        .alu_z    (alu_z),
        .mbr      (mbr),
        .load_req (load_req),
        .load_ack (load_ack),
        .load_we  (load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .mpc      (mpc),
        .busy     (busy)
    );

    // Synchronous control store: read data valid the cycle after cs_ren
    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (cs_wen) mem[cs_waddr] <= cs_wdata;
        if (cs_ren) cs_rdata <= mem[cs_raddr];
    end

    always @(negedge clk) begin
        if (cs_ren && cs_wen) n_coll <= n_coll + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [8:0] ref_next(input logic [35:0] w, input logic n,
                                            input logic z, input logic [7:0] m);
        int t;
        t = int'(w[35:27]);
        if (w[26]) t = t | int'(m);
        if ((w[24] && z) || (w[25] && n)) t = t | 256;
        return t[8:0];
    endfunction

    function automatic logic [35:0] mkword(input logic [8:0] na, input logic jmpc,
                                           input logic jamn, input logic jamz);
        logic [31:0] r;
        r = $urandom();
        return {na, jmpc, jamn, jamz, r[23:0]};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic poke(input logic [8:0] a, input logic [35:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        prog[a] = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        run_en = 1'b0;
        exec_done = 1'b0;
        load_req = 1'b0;
        load_we = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic exec_at_zero(input logic [35:0] w, input logic n,
                                input logic z, input logic [7:0] m);
        do_reset();
        poke(9'h000, w);
        run_en = 1'b1;
        tick();
        run_en = 1'b0;
        tick();
        exec_done = 1'b1;
        alu_n = n;
        alu_z = z;
        mbr = m;
        tick();
        exec_done = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        n_total++; if (cs_ren !== 1'b0) $display("FAIL rst_cs_ren: got %b want 0", cs_ren); else n_pass++;
        n_total++; if (cs_wen !== 1'b0) $display("FAIL rst_cs_wen: got %b want 0", cs_wen); else n_pass++;
        n_total++; if (cs_waddr !== 9'h0) $display("FAIL rst_cs_waddr: got %h want 000", cs_waddr); else n_pass++;
        n_total++; if (cs_wdata !== 36'h0) $display("FAIL rst_cs_wdata: got %h want 0", cs_wdata); else n_pass++;
        n_total++; if (mir_valid !== 1'b0) $display("FAIL rst_mir_valid: got %b want 0", mir_valid); else n_pass++;
        n_total++; if (load_ack !== 1'b0) $display("FAIL rst_load_ack: got %b want 0", load_ack); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (mpc !== 9'h000) $display("FAIL rst_mpc: got %h want 000", mpc); else n_pass++;
    endtask

    task automatic test_sequence;
        logic [35:0] w0;
        w0 = mkword(9'h005, 1'b0, 1'b0, 1'b0);
        do_reset();
        poke(9'h000, w0);
        poke(9'h005, mkword(9'h00A, 1'b0, 1'b0, 1'b0));
        exec_done = 1'b1;
        run_en = 1'b1;
        tick();
        n_total++; if (cs_ren !== 1'b1 || cs_raddr !== 9'h000) $display("FAIL seq_fetch0: ren=%b addr=%h want 1/000", cs_ren, cs_raddr); else n_pass++;
        n_total++; if (busy !== 1'b1 || mir_valid !== 1'b0) $display("FAIL seq_fetch0_flags: busy=%b mir=%b want 1/0", busy, mir_valid); else n_pass++;
        tick();
        n_total++; if (mir_valid !== 1'b1 || cs_ren !== 1'b0) $display("FAIL seq_exec0: mir=%b ren=%b want 1/0", mir_valid, cs_ren); else n_pass++;
        n_total++; if (cs_rdata !== w0) $display("FAIL seq_mir0: got %h want %h", cs_rdata, w0); else n_pass++;
        tick();
        n_total++; if (cs_ren !== 1'b1 || cs_raddr !== 9'h005 || mir_valid !== 1'b0) $display("FAIL seq_fetch5: ren=%b addr=%h mir=%b want 1/005/0", cs_ren, cs_raddr, mir_valid); else n_pass++;
        tick();
        n_total++; if (mir_valid !== 1'b1) $display("FAIL seq_exec5: mir=%b want 1", mir_valid); else n_pass++;
        run_en = 1'b0;
        tick();
        exec_done = 1'b0;
        n_total++; if (busy !== 1'b0 || mpc !== 9'h00A || cs_ren !== 1'b0) $display("FAIL seq_idle: busy=%b mpc=%h ren=%b want 0/00a/0", busy, mpc, cs_ren); else n_pass++;
    endtask

    task automatic test_cond_jumps;
        // {jamn, jamz, alu_n, alu_z, expected mpc}
        logic [12:0] tbl [7];
        tbl[0] = {4'b0101, 9'h112};
        tbl[1] = {4'b0100, 9'h012};
        tbl[2] = {4'b1010, 9'h112};
        tbl[3] = {4'b1000, 9'h012};
        tbl[4] = {4'b1100, 9'h012};
        tbl[5] = {4'b0110, 9'h012};
        tbl[6] = {4'b1111, 9'h112};
        for (int i = 0; i < 7; i++) begin
            exec_at_zero(mkword(9'h012, 1'b0, tbl[i][12], tbl[i][11]), tbl[i][10], tbl[i][9], 8'hFF);
            n_total++; if (mpc !== tbl[i][8:0]) $display("FAIL cond_jump[%0d]: mpc=%h want %h", i, mpc, tbl[i][8:0]); else n_pass++;
        end
    endtask

    task automatic test_jmpc;
        exec_at_zero(mkword(9'h100, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 8'h36);
        n_total++; if (mpc !== 9'h136) $display("FAIL jmpc_hi: mpc=%h want 136", mpc); else n_pass++;
        exec_at_zero(mkword(9'h003, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0, 8'h30);
        n_total++; if (mpc !== 9'h033) $display("FAIL jmpc_or: mpc=%h want 033", mpc); else n_pass++;
        exec_at_zero(mkword(9'h012, 1'b1, 1'b0, 1'b1), 1'b0, 1'b1, 8'h81);
        n_total++; if (mpc !== 9'h193) $display("FAIL jmpc_jamz: mpc=%h want 193", mpc); else n_pass++;
        exec_at_zero(mkword(9'h055, 1'b0, 1'b0, 1'b0), 1'b1, 1'b1, 8'hAA);
        n_total++; if (mpc !== 9'h055) $display("FAIL no_jmpc: mpc=%h want 055", mpc); else n_pass++;
    endtask

    task automatic test_delayed_done;
        logic [35:0] w;
        w = mkword(9'h0C3, 1'b0, 1'b0, 1'b0);
        do_reset();
        poke(9'h000, w);
        run_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_total++; if (mir_valid !== 1'b1 || cs_ren !== 1'b0) $display("FAIL delay_hold[%0d]: mir=%b ren=%b want 1/0", i, mir_valid, cs_ren); else n_pass++;
            n_total++; if (cs_rdata !== w || mpc !== 9'h000) $display("FAIL delay_stable[%0d]: mir=%h mpc=%h want %h/000", i, cs_rdata, mpc, w); else n_pass++;
            if (i == 4) exec_done = 1'b1;
            tick();
        end
        n_total++; if (cs_ren !== 1'b1 || cs_raddr !== 9'h0C3 || mir_valid !== 1'b0) $display("FAIL delay_next: ren=%b addr=%h mir=%b want 1/0c3/0", cs_ren, cs_raddr, mir_valid); else n_pass++;
        run_en = 1'b0;
        tick();
        tick();
        exec_done = 1'b0;
    endtask

    task automatic test_load;
        do_reset();
        poke(9'h000, mkword(9'h021, 1'b0, 1'b0, 1'b0));
        run_en = 1'b1;
        tick();
        tick();
        load_req = 1'b1;
        load_we = 1'b1;
        load_addr = 9'h0AA;
        load_data = 36'h5;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++; if (load_ack !== 1'b0 || mir_valid !== 1'b1 || cs_wen !== 1'b0) $display("FAIL load_wait[%0d]: ack=%b mir=%b wen=%b want 0/1/0", i, load_ack, mir_valid, cs_wen); else n_pass++;
        end
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        run_en = 1'b0;
        n_total++; if (load_ack !== 1'b1 || mir_valid !== 1'b0 || busy !== 1'b0) $display("FAIL load_enter: ack=%b mir=%b busy=%b want 1/0/0", load_ack, mir_valid, busy); else n_pass++;
        n_total++; if (mpc !== 9'h021 || cs_wen !== 1'b0) $display("FAIL load_enter_mpc: mpc=%h wen=%b want 021/0", mpc, cs_wen); else n_pass++;
        load_we = 1'b1;
        load_addr = 9'h1FF;
        load_data = 36'hABCDE0123;
        tick();
        n_total++; if (cs_wen !== 1'b1 || cs_waddr !== 9'h1FF || cs_wdata !== 36'hABCDE0123) $display("FAIL load_write: wen=%b addr=%h data=%h want 1/1ff/abcde0123", cs_wen, cs_waddr, cs_wdata); else n_pass++;
        load_we = 1'b0;
        tick();
        n_total++; if (cs_wen !== 1'b0) $display("FAIL load_pulse: wen=%b want 0", cs_wen); else n_pass++;
        n_total++; if (mem[9'h1FF] !== 36'hABCDE0123) $display("FAIL load_mem: mem=%h want abcde0123", mem[9'h1FF]); else n_pass++;
        load_req = 1'b0;
        tick();
        n_total++; if (load_ack !== 1'b0 || mpc !== 9'h000 || busy !== 1'b0) $display("FAIL load_exit: ack=%b mpc=%h busy=%b want 0/000/0", load_ack, mpc, busy); else n_pass++;
        n_total++; if (cs_waddr !== 9'h0 || cs_wdata !== 36'h0) $display("FAIL load_clear: addr=%h data=%h want 0/0", cs_waddr, cs_wdata); else n_pass++;
        run_en = 1'b1;
        load_req = 1'b1;
        tick();
        n_total++; if (load_ack !== 1'b1 || cs_ren !== 1'b0) $display("FAIL load_priority: ack=%b ren=%b want 1/0", load_ack, cs_ren); else n_pass++;
        run_en = 1'b0;
        load_req = 1'b0;
        tick();
        n_total++; if (n_coll !== 0) $display("FAIL no_collision: got %0d want 0", n_coll); else n_pass++;
    endtask

    task automatic test_async_reset;
        do_reset();
        poke(9'h000, mkword(9'h005, 1'b0, 1'b0, 1'b0));
        poke(9'h005, mkword(9'h077, 1'b0, 1'b0, 1'b0));
        run_en = 1'b1;
        exec_done = 1'b1;
        tick();
        tick();
        tick();
        exec_done = 1'b0;
        tick();
        n_total++; if (mpc !== 9'h005 || mir_valid !== 1'b1) $display("FAIL arst_pre_exec: mpc=%h mir=%b want 005/1", mpc, mir_valid); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (mir_valid !== 1'b0 || busy !== 1'b0 || cs_ren !== 1'b0 || mpc !== 9'h000) $display("FAIL arst_exec: mir=%b busy=%b ren=%b mpc=%h want 0/0/0/000", mir_valid, busy, cs_ren, mpc); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (cs_ren !== 1'b1 || cs_raddr !== 9'h000) $display("FAIL arst_resume: ren=%b addr=%h want 1/000", cs_ren, cs_raddr); else n_pass++;
        run_en = 1'b0;
        exec_done = 1'b1;
        tick();
        tick();
        exec_done = 1'b0;
        load_req = 1'b1;
        tick();
        load_we = 1'b1;
        load_addr = 9'h055;
        load_data = 36'h123456789;
        tick();
        n_total++; if (cs_wen !== 1'b1 || load_ack !== 1'b1) $display("FAIL arst_pre_load: wen=%b ack=%b want 1/1", cs_wen, load_ack); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (cs_wen !== 1'b0 || load_ack !== 1'b0 || cs_waddr !== 9'h0 || cs_wdata !== 36'h0 || mpc !== 9'h000) $display("FAIL arst_load: wen=%b ack=%b addr=%h data=%h mpc=%h want all 0", cs_wen, load_ack, cs_waddr, cs_wdata, mpc); else n_pass++;
        load_req = 1'b0;
        load_we = 1'b0;
        run_en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        n_total++; if (cs_ren !== 1'b1 || cs_raddr !== 9'h000 || load_ack !== 1'b0) $display("FAIL arst_load_resume: ren=%b addr=%h ack=%b want 1/000/0", cs_ren, cs_raddr, load_ack); else n_pass++;
        run_en = 1'b0;
        exec_done = 1'b1;
        tick();
        tick();
        exec_done = 1'b0;
    endtask

    task automatic test_random_walk;
        logic [63:0] r;
        logic [8:0]  exp_addr;
        int          d;
        do_reset();
        for (int i = 0; i < 512; i++) begin
            r = {$urandom(), $urandom()};
            poke(9'(i), r[35:0]);
        end
        exp_addr = 9'h000;
        run_en = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            n_total++; if (cs_ren !== 1'b1 || cs_raddr !== exp_addr || busy !== 1'b1) $display("FAIL rnd_fetch[%0d]: ren=%b addr=%h busy=%b want 1/%h/1", k, cs_ren, cs_raddr, busy, exp_addr); else n_pass++;
            exec_done = 1'b0;
            tick();
            n_total++; if (mir_valid !== 1'b1 || cs_rdata !== prog[exp_addr]) $display("FAIL rnd_mir[%0d]: mir=%b data=%h want 1/%h", k, mir_valid, cs_rdata, prog[exp_addr]); else n_pass++;
            d = $urandom_range(0, 3);
            for (int j = 0; j < d; j++) begin
                tick();
                n_total++; if (mir_valid !== 1'b1 || cs_ren !== 1'b0 || mpc !== exp_addr) $display("FAIL rnd_hold[%0d]: mir=%b ren=%b mpc=%h want 1/0/%h", k, mir_valid, cs_ren, mpc, exp_addr); else n_pass++;
            end
            exec_done = 1'b1;
            alu_n = 1'($urandom());
            alu_z = 1'($urandom());
            mbr = 8'($urandom());
            exp_addr = ref_next(prog[exp_addr], alu_n, alu_z, mbr);
            tick();
        end
        run_en = 1'b0;
        tick();
        tick();
        exec_done = 1'b0;
        n_total++; if (busy !== 1'b0 || cs_ren !== 1'b0) $display("FAIL rnd_park: busy=%b ren=%b want 0/0", busy, cs_ren); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        run_en = 1'b0;
        exec_done = 1'b0;
        alu_n = 1'b0;
        alu_z = 1'b0;
        mbr = 8'h00;
        load_req = 1'b0;
        load_we = 1'b0;
        load_addr = 9'h0;
        load_data = 36'h0;
        tb_we = 1'b0;
        tb_wa = 9'h0;
        tb_wd = 36'h0;
        test_reset();
        test_sequence();
        test_cond_jumps();
        test_jmpc();
        test_delayed_done();
        test_load();
        test_async_reset();
        test_random_walk();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mic1_microsequencer.md
Name: mic1_microsequencer

Overview:
- Microsequencer for the MIC-1 control store.
- Holds MPC, issues control-store reads, presents each fetched microinstruction (MIR) to the datapath for one execute phase, and computes the next MPC from NEXT_ADDRESS, JAMN/JAMZ/JMPC, the ALU flags and MBR.
- Also owns the control store's write port: an external loader can write a microprogram between microinstructions, with no write/read collision.

Parameters:
- RESET_MPC, 9'h000, MPC value loaded at reset and after a load session.
- ADDR_W, 9, control store address width. Fixed by MIC-1; assert if not 9.
- WORD_W, 36, microinstruction width. Fixed by MIC-1; assert if not 36.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run_en  in  1  enables fetch; 0 parks the sequencer at the next instruction boundary.
- cs_ren  out  1  control store read enable.
- cs_raddr  out  9  control store read address (= MPC).
- cs_rdata  in  36  control store read data; valid the cycle after cs_ren.
- cs_wen  out  1  control store write enable.
- cs_waddr  out  9  control store write address.
- cs_wdata  out  36  control store write data.
- mir_valid  out  1  cs_rdata holds the current MIR; the datapath executes it.
- exec_done  in  1  datapath finished the current microinstruction; alu_n/alu_z are valid.
- alu_n  in  1  ALU negative flag.
- alu_z  in  1  ALU zero flag.
- mbr  in  8  MBR contents, used by JMPC.
- load_req  in  1  loader requests ownership of the write port.
- load_ack  out  1  write port granted to the loader.
- load_we  in  1  loader write strobe, honoured only while load_ack=1.
- load_addr  in  9  loader write address.
- load_data  in  36  loader write data.
- mpc  out  9  current MPC, for debug.
- busy  out  1  1 in FETCH or EXEC.

Behaviour:
- States: IDLE, FETCH, EXEC, LOAD.
- Reset (async, rst_n=0):
  - state=IDLE, mpc=RESET_MPC.
  - cs_ren=0, cs_wen=0, cs_waddr=0, cs_wdata=0.
  - mir_valid=0, load_ack=0, busy=0.
- IDLE:
  - load_req=1 → LOAD; load_req has priority over run_en.
  - Else run_en=1 → FETCH.
- FETCH (1 cycle):
  - cs_ren=1, cs_raddr=mpc.
  - Next state is always EXEC.
- EXEC:
  - mir_valid=1, cs_ren=0; waits indefinitely for exec_done.
  - When exec_done=1, with NA=cs_rdata[35:27], JMPC=[26], JAMN=[25], JAMZ=[24]:
    - next[8] = NA[8] | (JAMZ & alu_z) | (JAMN & alu_n).
    - next[7:0] = JMPC ? (NA[7:0] | mbr) : NA[7:0].
    - mpc <= next.
  - Then:
    - load_req=1 → LOAD.
    - Else run_en=1 → FETCH.
    - Else → IDLE.
  - Latency: 2 cycles per microinstruction when exec_done is high in the first EXEC cycle.
  - cs_rdata must be stable throughout EXEC. Met because cs_ren=0 there.
  - Dropping run_en, or raising load_req, mid-EXEC takes effect only at exec_done; the instruction is never aborted.
- LOAD:
  - load_ack=1.
  - cs_wen=load_we, cs_waddr=load_addr, cs_wdata=load_data, registered: the write lands 1 cycle after the strobe.
  - cs_ren is held at 0 throughout LOAD.
  - On load_req deassertion: mpc <= RESET_MPC, load_ack=0 next cycle, → IDLE.
  - Write registers clear to 0 on exit.
  - load_we with load_ack=0 is ignored.
- cs_wen and cs_ren are never both 1 in the same cycle.
- mpc wraps naturally at 9 bits; no overflow detection.
- busy=1 in FETCH or EXEC.

Test Plan:
- Reset, run_en=1, store word @0x000 has NA=0x005, no jumps, exec_done same cycle:
  - cs_raddr=0x000 then 0x005.
  - 2-cycle period.
  - mir_valid high 1 cycle each.
- Conditional jumps, NA=0x012 with JAMZ=1:
  - alu_z=1 → next MPC 0x112.
  - alu_z=0 → 0x012.
  - Repeat with JAMN/alu_n.
  - JAMZ+JAMN both set, both flags 0 → 0x012.
- JMPC, NA=0x100, mbr=0x36 → mpc=0x136.
  - NA=0x003, mbr=0x30 → 0x033 (OR, not add).
- exec_done delayed 5 cycles:
  - mir_valid held 5 cycles; cs_rdata unchanged.
  - cs_ren low; mpc unchanged until the done cycle.
- load_req asserted mid-EXEC:
  - load_ack only after exec_done.
  - Write 0x1FF=36'hABCDE0123 → cs_wen pulse with those values one cycle later.
  - Drop load_req → mpc=RESET_MPC, IDLE.
  - No cycle with cs_ren & cs_wen.
- rst_n low during EXEC and during LOAD:
  - All outputs go to reset values immediately (async).
  - Resumes from IDLE with mpc=RESET_MPC.
